// File: rtl/test_i9672_trigger_monitor_pkg.sv
// Shared types for the I9672 trigger monitor: FSM states and trigger-cause codes.
package trig_mon_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED} state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_RUN  = 2'b01;
  localparam logic [1:0] CAUSE_SEQ  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;
endpackage

// File: rtl/test_i9672_trigger_monitor_if.sv
// Observer bus: sampled net and controls in, statistics and trigger status out.
interface test_i9672_trigger_monitor_if #(
  parameter int CNT_W = 16,
  parameter int RUN_W = 8
);
  logic             I9672;
  logic             sample_en;
  logic             arm;
  logic             clear;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] toggle_cnt;
  logic [RUN_W-1:0] max_run;
  logic             trigger;
  logic [1:0]       trig_cause;

  modport master (
    output I9672, sample_en, arm, clear,
    input  high_cnt, toggle_cnt, max_run, trigger, trig_cause
  );

  modport slave (
    input  I9672, sample_en, arm, clear,
    output high_cnt, toggle_cnt, max_run, trigger, trig_cause
  );
endinterface

// File: rtl/test_i9672_trigger_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)                 q_d = '0;
    else if (inc && ~&q_q)   q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/test_i9672_trigger_monitor.sv
// Rare-activation detector on net I9672: activity statistics plus a sticky trigger
// fired by a long high run or a programmed sample pattern.
module test_i9672_trigger_monitor
  import trig_mon_pkg::*;
#(
  parameter int                   CNT_W       = 16,
  parameter int                   RUN_W       = 8,
  parameter int                   RUN_THRESH  = 4,
  parameter int                   SEQ_LEN     = 4,
  parameter logic [SEQ_LEN-1:0]   SEQ_PATTERN = 4'b1011
) (
  input  logic                          I1470,
  input  logic                          I1477,
  test_i9672_trigger_monitor_if.slave   bus
);
  localparam int NV_W = $clog2(SEQ_LEN + 1);

  logic               samp, s;
  logic [RUN_W-1:0]   run_q, run_nxt;
  logic [RUN_W-1:0]   max_q, max_d;
  logic [SEQ_LEN-1:0] window_q, window_d, window_nxt;
  logic [NV_W-1:0]    nvalid_q, nvalid_d, nvalid_nxt;
  logic               prev_q, prev_d, prev_valid_q, prev_valid_d;
  logic               run_hit, seq_hit;
  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;

  // A sample coinciding with clear is dropped entirely.
  assign samp = bus.sample_en & ~bus.clear;
  assign s    = bus.I9672;

  sat_counter #(.W(CNT_W)) u_high (
    .clk(I1470), .rst_n(I1477), .inc(samp & s), .clr(bus.clear), .q(bus.high_cnt)
  );

  sat_counter #(.W(CNT_W)) u_toggle (
    .clk(I1470), .rst_n(I1477), .inc(samp & prev_valid_q & (s ^ prev_q)),
    .clr(bus.clear), .q(bus.toggle_cnt)
  );

  sat_counter #(.W(RUN_W)) u_run (
    .clk(I1470), .rst_n(I1477), .inc(samp & s), .clr(bus.clear | (samp & ~s)), .q(run_q)
  );

  // Post-update values of this sampling edge, used by the hit terms and max tracker.
  assign run_nxt    = s ? (run_q + {{(RUN_W-1){1'b0}}, ~&run_q}) : '0;
  assign window_nxt = {window_q[SEQ_LEN-2:0], s};
  assign nvalid_nxt = (nvalid_q == NV_W'(SEQ_LEN)) ? nvalid_q : nvalid_q + 1'b1;
  assign run_hit    = samp && (run_nxt == RUN_W'(RUN_THRESH));
  assign seq_hit    = samp && (nvalid_nxt == NV_W'(SEQ_LEN)) && (window_nxt == SEQ_PATTERN);

  always_comb begin
    max_d        = max_q;
    window_d     = window_q;
    nvalid_d     = nvalid_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (bus.clear) begin
      max_d        = '0;
      window_d     = '0;
      nvalid_d     = '0;
      prev_valid_d = 1'b0;
    end else if (samp) begin
      if (run_nxt > max_q) max_d = run_nxt;
      window_d     = window_nxt;
      nvalid_d     = nvalid_nxt;
      prev_d       = s;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      max_q        <= '0;
      window_q     <= '0;
      nvalid_q     <= '0;
      prev_q       <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      max_q        <= max_d;
      window_q     <= window_d;
      nvalid_q     <= nvalid_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    if (bus.clear) begin
      state_d = bus.arm ? ARMED : IDLE;
      cause_d = CAUSE_NONE;
    end else begin
      unique case (state_q)
        IDLE:      if (bus.arm) state_d = ARMED;
        ARMED: begin
          if (run_hit | seq_hit) begin
            state_d = TRIGGERED;
            cause_d = {seq_hit, run_hit};
          end else if (!bus.arm) begin
            state_d = IDLE;
          end
        end
        TRIGGERED: state_d = TRIGGERED;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.max_run    = max_q;
  assign bus.trigger    = (state_q == TRIGGERED);
  assign bus.trig_cause = cause_q;
endmodule

// File: tb/tb_test_i9672_trigger_monitor.sv
// Bench for the I9672 trigger monitor: directed scenarios plus randomized traffic
// checked against a sample-history reference model.
module tb_test_i9672_trigger_monitor;
  localparam int         SEQ_LEN    = 4;
  localparam int         RUN_THRESH = 4;
  localparam logic [3:0] PAT        = 4'b1011;
  localparam int         CNT_MAX    = 65535;
  localparam int         RUN_MAX    = 255;
  localparam int         M_IDLE = 0, M_ARMED = 1, M_TRIG = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_i9672_trigger_monitor_if #(.CNT_W(16), .RUN_W(8)) if1 ();
  test_i9672_trigger_monitor_if #(.CNT_W(4),  .RUN_W(8)) if2 ();

  test_i9672_trigger_monitor dut1 (.I1470(clk), .I1477(rst_n), .bus(if1));
  test_i9672_trigger_monitor #(.CNT_W(4)) dut2 (.I1470(clk), .I1477(rst_n), .bus(if2));

  int checks   = 0;
  int failures = 0;

  // Reference model: counts as integers, recent samples kept as a history queue.
  int m_high, m_tog, m_run, m_max, m_state, m_cause;
  bit m_prev, m_pv;
  bit hist[$];

  function automatic void model_reset();
    m_high = 0; m_tog = 0; m_run = 0; m_max = 0; m_pv = 0; m_prev = 0;
    m_state = M_IDLE; m_cause = 0;
    hist.delete();
  endfunction

  function automatic void model_step(bit s, bit en, bit arm, bit clr);
    bit rh, sh;
    rh = 0; sh = 0;
    if (clr) begin
      m_high = 0; m_tog = 0; m_run = 0; m_max = 0; m_pv = 0;
      hist.delete();
      m_cause = 0;
      m_state = arm ? M_ARMED : M_IDLE;
      return;
    end
    if (en) begin
      if (s && m_high < CNT_MAX) m_high++;
      if (m_pv && s != m_prev && m_tog < CNT_MAX) m_tog++;
      m_run = s ? ((m_run < RUN_MAX) ? m_run + 1 : m_run) : 0;
      if (m_run > m_max) m_max = m_run;
      hist.push_back(s);
      if (hist.size() > SEQ_LEN) void'(hist.pop_front());
      m_prev = s; m_pv = 1;
      rh = (m_run == RUN_THRESH);
      if (hist.size() == SEQ_LEN) begin
        sh = 1;
        for (int i = 0; i < SEQ_LEN; i++) if (hist[SEQ_LEN-1-i] != PAT[i]) sh = 0;
      end
    end
    case (m_state)
      M_IDLE:  if (arm) m_state = M_ARMED;
      M_ARMED: begin
        if (rh || sh) begin
          m_state = M_TRIG;
          m_cause = (sh ? 2 : 0) + (rh ? 1 : 0);
        end else if (!arm) m_state = M_IDLE;
      end
      default: ;
    endcase
  endfunction

  task automatic cyc(input bit s, input bit en, input bit arm, input bit clr);
    if1.I9672 = s; if1.sample_en = en; if1.arm = arm; if1.clear = clr;
    @(posedge clk);
    model_step(s, en, arm, clr);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.I9672 = 1; if1.sample_en = 1; if1.arm = 1; if1.clear = 0;
    if2.I9672 = 1; if2.sample_en = 1; if2.arm = 1; if2.clear = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (if1.high_cnt !== 16'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", if1.high_cnt); end
    checks++; if (if1.toggle_cnt !== 16'd0) begin failures++; $display("FAIL reset_toggle got=%0d exp=0", if1.toggle_cnt); end
    checks++; if (if1.max_run !== 8'd0) begin failures++; $display("FAIL reset_maxrun got=%0d exp=0", if1.max_run); end
    checks++; if (if1.trigger !== 1'b0 || if1.trig_cause !== 2'b00) begin failures++; $display("FAIL reset_trig got=%b/%b exp=0/00", if1.trigger, if1.trig_cause); end
    checks++; if (if2.high_cnt !== 4'd0 || if2.trigger !== 1'b0) begin failures++; $display("FAIL reset_dut2 got=%0d/%b exp=0/0", if2.high_cnt, if2.trigger); end
    if1.sample_en = 0; if1.arm = 0; if1.I9672 = 0;
    if2.sample_en = 0; if2.arm = 0; if2.I9672 = 0; if2.clear = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stats();
    bit seq[7] = '{1, 1, 0, 1, 1, 1, 0};
    foreach (seq[i]) begin
      cyc(seq[i], 1, 0, 0);
      cyc(1, 0, 0, 0);
    end
    checks++; if (if1.high_cnt !== 16'd5) begin failures++; $display("FAIL stats_high got=%0d exp=5", if1.high_cnt); end
    checks++; if (if1.toggle_cnt !== 16'd3) begin failures++; $display("FAIL stats_toggle got=%0d exp=3", if1.toggle_cnt); end
    checks++; if (if1.max_run !== 8'd3) begin failures++; $display("FAIL stats_maxrun got=%0d exp=3", if1.max_run); end
    checks++; if (if1.trigger !== 1'b0) begin failures++; $display("FAIL stats_trig got=%b exp=0", if1.trigger); end
  endtask

  task automatic test_run_trigger();
    cyc(0, 0, 1, 1);
    checks++; if (if1.high_cnt !== 16'd0 || if1.max_run !== 8'd0) begin failures++; $display("FAIL run_clear got=%0d/%0d exp=0/0", if1.high_cnt, if1.max_run); end
    repeat (3) cyc(1, 1, 1, 0);
    checks++; if (if1.trigger !== 1'b0) begin failures++; $display("FAIL run_early got=%b exp=0", if1.trigger); end
    cyc(1, 1, 1, 0);
    checks++; if (if1.trigger !== 1'b1 || if1.trig_cause !== 2'b01) begin failures++; $display("FAIL run_fire got=%b/%b exp=1/01", if1.trigger, if1.trig_cause); end
    repeat (2) cyc(0, 0, 0, 0);
    checks++; if (if1.trigger !== 1'b1 || if1.trig_cause !== 2'b01) begin failures++; $display("FAIL run_sticky got=%b/%b exp=1/01", if1.trigger, if1.trig_cause); end
  endtask

  task automatic test_seq_trigger();
    cyc(0, 0, 1, 1);
    cyc(1, 1, 1, 0); cyc(0, 1, 1, 0); cyc(1, 1, 1, 0);
    checks++; if (if1.trigger !== 1'b0) begin failures++; $display("FAIL seq_three got=%b exp=0", if1.trigger); end
    cyc(1, 1, 1, 0);
    checks++; if (if1.trigger !== 1'b1 || if1.trig_cause !== 2'b10) begin failures++; $display("FAIL seq_fire got=%b/%b exp=1/10", if1.trigger, if1.trig_cause); end
  endtask

  task automatic test_clear_priority();
    cyc(1, 1, 1, 1);
    checks++; if (if1.trigger !== 1'b0 || if1.trig_cause !== 2'b00) begin failures++; $display("FAIL clr_trig got=%b/%b exp=0/00", if1.trigger, if1.trig_cause); end
    checks++; if (if1.high_cnt !== 16'd0 || if1.toggle_cnt !== 16'd0 || if1.max_run !== 8'd0) begin failures++; $display("FAIL clr_stats got=%0d/%0d/%0d exp=0/0/0", if1.high_cnt, if1.toggle_cnt, if1.max_run); end
    cyc(1, 1, 1, 0); cyc(0, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
    checks++; if (if1.trigger !== 1'b1 || if1.trig_cause !== 2'b10) begin failures++; $display("FAIL clr_armed got=%b/%b exp=1/10", if1.trigger, if1.trig_cause); end
    checks++; if (if1.high_cnt !== 16'd3 || if1.toggle_cnt !== 16'd2) begin failures++; $display("FAIL clr_after got=%0d/%0d exp=3/2", if1.high_cnt, if1.toggle_cnt); end
  endtask

  task automatic test_saturation();
    if2.I9672 = 1; if2.sample_en = 1;
    repeat (20) cyc(0, 0, 0, 0);
    if2.sample_en = 0;
    checks++; if (if2.high_cnt !== 4'd15) begin failures++; $display("FAIL sat_high got=%0d exp=15", if2.high_cnt); end
    checks++; if (if2.toggle_cnt !== 4'd0) begin failures++; $display("FAIL sat_toggle got=%0d exp=0", if2.toggle_cnt); end
    checks++; if (if2.max_run !== 8'd20) begin failures++; $display("FAIL sat_maxrun got=%0d exp=20", if2.max_run); end
    if2.sample_en = 1;
    repeat (3) cyc(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (if2.high_cnt !== 4'd0 || if2.max_run !== 8'd0) begin failures++; $display("FAIL sat_async got=%0d/%0d exp=0/0", if2.high_cnt, if2.max_run); end
    checks++; if (if1.trigger !== 1'b0 || if1.high_cnt !== 16'd0) begin failures++; $display("FAIL async_dut1 got=%b/%0d exp=0/0", if1.trigger, if1.high_cnt); end
    @(posedge clk); #1;
    if2.sample_en = 0; if2.I9672 = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit arm_r, s, en, clr;
    arm_r = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) arm_r = ~arm_r;
      clr = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 9) < 7);
      cyc(s, en, arm_r, clr);
      checks++; if (if1.high_cnt !== 16'(m_high)) begin failures++; $display("FAIL rnd_high n=%0d got=%0d exp=%0d", n, if1.high_cnt, m_high); end
      checks++; if (if1.toggle_cnt !== 16'(m_tog)) begin failures++; $display("FAIL rnd_toggle n=%0d got=%0d exp=%0d", n, if1.toggle_cnt, m_tog); end
      checks++; if (if1.max_run !== 8'(m_max)) begin failures++; $display("FAIL rnd_maxrun n=%0d got=%0d exp=%0d", n, if1.max_run, m_max); end
      checks++; if (if1.trigger !== (m_state == M_TRIG)) begin failures++; $display("FAIL rnd_trig n=%0d got=%b exp=%0d", n, if1.trigger, m_state == M_TRIG); end
      checks++; if (if1.trig_cause !== 2'(m_cause)) begin failures++; $display("FAIL rnd_cause n=%0d got=%b exp=%0d", n, if1.trig_cause, m_cause); end
    end
  endtask

  initial begin
    if1.I9672 = 0; if1.sample_en = 0; if1.arm = 0; if1.clear = 0;
    if2.I9672 = 0; if2.sample_en = 0; if2.arm = 0; if2.clear = 0;
    model_reset();
    test_reset();
    test_stats();
    test_run_trigger();
    test_seq_trigger();
    test_clear_priority();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
